tl_ul_a_arbiter_2to1: RTL

- Two-requester TileLink-UL (single-beat) arbiter that shares one downstream A/D port between two upstream masters.
- Sits in front of the monitored slave-side port.
- Round-robin grant on A, with a stable grant while a beat is stalled.
- Widens source by one bit to tag the requester, and routes D responses back using that bit.
- Limits outstanding requests per requester and flags unexpected responses.

---
 rtl/tl_ul_a_arbiter_2to1.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/tl_ul_a_arbiter_2to1.sv
// Two-requester TileLink-UL A-channel arbiter: round-robin grant held across stalls,
// source widened by a requester-id bit that steers D responses back to their owner.
module tl_ul_a_arbiter_2to1 #(
    parameter int MAX_INFLIGHT = 2
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        in0_a_valid,
    output logic        in0_a_ready,
    input  logic [2:0]  in0_a_opcode,
    input  logic [2:0]  in0_a_param,
    input  logic [3:0]  in0_a_size,
    input  logic        in0_a_source,
    input  logic [31:0] in0_a_address,
    input  logic [3:0]  in0_a_mask,
    input  logic [31:0] in0_a_data,

    input  logic        in1_a_valid,
    output logic        in1_a_ready,
    input  logic [2:0]  in1_a_opcode,
    input  logic [2:0]  in1_a_param,
    input  logic [3:0]  in1_a_size,
    input  logic        in1_a_source,
    input  logic [31:0] in1_a_address,
    input  logic [3:0]  in1_a_mask,
    input  logic [31:0] in1_a_data,

    output logic        in0_d_valid,
    input  logic        in0_d_ready,
    output logic [2:0]  in0_d_opcode,
    output logic [3:0]  in0_d_size,
    output logic        in0_d_source,
    output logic        in0_d_denied,
    output logic [31:0] in0_d_data,

    output logic        in1_d_valid,
    input  logic        in1_d_ready,
    output logic [2:0]  in1_d_opcode,
    output logic [3:0]  in1_d_size,
    output logic        in1_d_source,
    output logic        in1_d_denied,
    output logic [31:0] in1_d_data,

    output logic        out_a_valid,
    input  logic        out_a_ready,
    output logic [2:0]  out_a_opcode,
    output logic [2:0]  out_a_param,
    output logic [3:0]  out_a_size,
    output logic [1:0]  out_a_source,
    output logic [31:0] out_a_address,
    output logic [3:0]  out_a_mask,
    output logic [31:0] out_a_data,

    input  logic        out_d_valid,
    output logic        out_d_ready,
    input  logic [2:0]  out_d_opcode,
    input  logic [3:0]  out_d_size,
    input  logic [1:0]  out_d_source,
    input  logic        out_d_denied,
    input  logic [31:0] out_d_data,

    output logic        err_unexpected_d
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic          lock_q, lock_d;
    logic          lock_id_q, lock_id_d;
    logic          err_q, err_d;

    logic elig0, elig1, grant_id, a_fire, d_id, d_fire;
    logic inc0, inc1, dec0, dec1;

    // A-side grant and mux; a locked grant ignores eligibility so a stalled beat keeps its source.
    always_comb begin
        elig0 = in0_a_valid && (cnt0_q < CNT_MAX);
        elig1 = in1_a_valid && (cnt1_q < CNT_MAX);

        if (lock_q) begin
            grant_id = lock_id_q;
        end else if (elig0 && elig1) begin
            grant_id = rr_ptr_q;
        end else begin
            grant_id = elig1;
        end

        out_a_valid   = grant_id ? elig1 : elig0;
        a_fire        = out_a_valid && out_a_ready;
        in0_a_ready   = !grant_id && out_a_ready && (cnt0_q < CNT_MAX);
        in1_a_ready   =  grant_id && out_a_ready && (cnt1_q < CNT_MAX);

        out_a_opcode  = grant_id ? in1_a_opcode  : in0_a_opcode;
        out_a_param   = grant_id ? in1_a_param   : in0_a_param;
        out_a_size    = grant_id ? in1_a_size    : in0_a_size;
        out_a_source  = {grant_id, grant_id ? in1_a_source : in0_a_source};
        out_a_address = grant_id ? in1_a_address : in0_a_address;
        out_a_mask    = grant_id ? in1_a_mask    : in0_a_mask;
        out_a_data    = grant_id ? in1_a_data    : in0_a_data;
    end

    // D-side steering by the requester-id bit of the widened source.
    always_comb begin
        d_id         = out_d_source[1];
        in0_d_valid  = out_d_valid && !d_id;
        in1_d_valid  = out_d_valid &&  d_id;
        out_d_ready  = d_id ? in1_d_ready : in0_d_ready;
        d_fire       = out_d_valid && out_d_ready;

        in0_d_opcode = out_d_opcode;
        in0_d_size   = out_d_size;
        in0_d_source = out_d_source[0];
        in0_d_denied = out_d_denied;
        in0_d_data   = out_d_data;
        in1_d_opcode = out_d_opcode;
        in1_d_size   = out_d_size;
        in1_d_source = out_d_source[0];
        in1_d_denied = out_d_denied;
        in1_d_data   = out_d_data;
    end

    // Inflight counters saturate at both ends; a response to an idle requester is flagged, not counted.
    always_comb begin
        inc0      = a_fire && !grant_id;
        inc1      = a_fire &&  grant_id;
        dec0      = d_fire && !d_id;
        dec1      = d_fire &&  d_id;

        cnt0_d    = cnt0_q;
        cnt1_d    = cnt1_q;
        err_d     = err_q;
        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;

        if (inc0 && !dec0 && (cnt0_q != CNT_MAX)) begin
            cnt0_d = cnt0_q + CNT_ONE;
        end else if (dec0 && !inc0) begin
            if (cnt0_q == '0) begin
                err_d = 1'b1;
            end else begin
                cnt0_d = cnt0_q - CNT_ONE;
            end
        end

        if (inc1 && !dec1 && (cnt1_q != CNT_MAX)) begin
            cnt1_d = cnt1_q + CNT_ONE;
        end else if (dec1 && !inc1) begin
            if (cnt1_q == '0) begin
                err_d = 1'b1;
            end else begin
                cnt1_d = cnt1_q - CNT_ONE;
            end
        end

        if (a_fire) begin
            rr_ptr_d = ~grant_id;
            lock_d   = 1'b0;
        end else if (out_a_valid) begin
            lock_d    = 1'b1;
            lock_id_d = grant_id;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt0_q    <= '0;
            cnt1_q    <= '0;
            rr_ptr_q  <= 1'b0;
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            err_q     <= err_d;
        end
    end

    assign err_unexpected_d = err_q;

endmodule
